cmul_share_ctrl: RTL and testbench

Two-requester scheduler that time-shares one combinational complex multiplier (`Multiply`, Q1.(WIDTH-1) operands, products scaled by `>>> (WIDTH-1)`) between FFT butterfly stages. Each requester presents operand pairs on a valid/ready port. The block arbitrates round-robin and registers the winning operands onto the multiplier inputs. It captures the multiplier outputs into a result register and returns each result with the requester ID on a single valid/ready output port. The multiplier instance sits outside this block, wired to the `mul_*` ports.

---
 rtl/cmul_share_ctrl.sv | 117 +++++++++++
 tb/tb_cmul_share_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_share_ctrl.sv
// Round-robin scheduler sharing one external complex multiplier between two
// requesters: S1 registers the winning operands onto mul_*, S2 captures the product.
module cmul_share_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a_re,
  input  logic [WIDTH-1:0] r0_a_im,
  input  logic [WIDTH-1:0] r0_b_re,
  input  logic [WIDTH-1:0] r0_b_im,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a_re,
  input  logic [WIDTH-1:0] r1_a_im,
  input  logic [WIDTH-1:0] r1_b_re,
  input  logic [WIDTH-1:0] r1_b_im,
  output logic [WIDTH-1:0] mul_a_re,
  output logic [WIDTH-1:0] mul_a_im,
  output logic [WIDTH-1:0] mul_b_re,
  output logic [WIDTH-1:0] mul_b_im,
  input  logic [WIDTH-1:0] mul_m_re,
  input  logic [WIDTH-1:0] mul_m_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);

  // Handshake: a word moves on a rising edge where valid && ready are both high.
  // rN_ready may depend on rN_valid (it is only raised for the granted, valid
  // requester); requesters must hold valid and data stable until accepted.

  localparam int OW = 4 * WIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_id_q, s1_id_d;
  logic [OW-1:0] ops_q, ops_d;
  logic          last_q, last_d;
  logic          out_valid_q, out_valid_d;
  logic          out_id_q, out_id_d;
  logic [WIDTH-1:0] out_re_q, out_re_d;
  logic [WIDTH-1:0] out_im_q, out_im_d;

  logic adv1, adv2, grant_id, xfer;

  always_comb begin
    adv2     = !out_valid_q || out_ready;
    adv1     = !s1_valid_q || adv2;
    grant_id = (r0_valid && r1_valid) ? !last_q : r1_valid;
    // Ready is held low during reset so nothing is acknowledged and then discarded.
    xfer     = adv1 && (r0_valid || r1_valid) && !reset;
    r0_ready = xfer && !grant_id;
    r1_ready = xfer && grant_id;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    ops_d       = ops_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (adv1) begin
      s1_valid_d = xfer;
    end
    if (xfer) begin
      s1_id_d = grant_id;
      last_d  = grant_id;
      ops_d   = grant_id ? {r1_a_re, r1_a_im, r1_b_re, r1_b_im}
                         : {r0_a_re, r0_a_im, r0_b_re, r0_b_im};
    end
    if (adv2) begin
      out_valid_d = s1_valid_q;
      out_id_d    = s1_id_q;
      out_re_d    = mul_m_re;
      out_im_d    = mul_m_im;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= 1'b0;
      ops_q       <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      ops_q       <= ops_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign mul_a_re  = ops_q[4*WIDTH-1:3*WIDTH];
  assign mul_a_im  = ops_q[3*WIDTH-1:2*WIDTH];
  assign mul_b_re  = ops_q[2*WIDTH-1:WIDTH];
  assign mul_b_im  = ops_q[WIDTH-1:0];
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_cmul_share_ctrl.sv
// Directed bench for cmul_share_ctrl with a behavioural complex multiplier on mul_*.
module tb_cmul_share_ctrl;

  localparam int W  = 16;
  localparam int EW = 2 * W + 1;
  localparam int LW = 2 * W + 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         r0_valid = 1'b0, r1_valid = 1'b0;
  logic         r0_ready, r1_ready;
  logic [W-1:0] r0_a_re = '0, r0_a_im = '0, r0_b_re = '0, r0_b_im = '0;
  logic [W-1:0] r1_a_re = '0, r1_a_im = '0, r1_b_re = '0, r1_b_im = '0;
  logic [W-1:0] mul_a_re, mul_a_im, mul_b_re, mul_b_im;
  logic [W-1:0] mul_m_re, mul_m_im;
  logic         out_valid, out_id;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_re, out_im;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clock = ~clock;

  cmul_share_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready),
    .r0_a_re(r0_a_re), .r0_a_im(r0_a_im), .r0_b_re(r0_b_re), .r0_b_im(r0_b_im),
    .r1_valid(r1_valid), .r1_ready(r1_ready),
    .r1_a_re(r1_a_re), .r1_a_im(r1_a_im), .r1_b_re(r1_b_re), .r1_b_im(r1_b_im),
    .mul_a_re(mul_a_re), .mul_a_im(mul_a_im), .mul_b_re(mul_b_re), .mul_b_im(mul_b_im),
    .mul_m_re(mul_m_re), .mul_m_im(mul_m_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_re(out_re), .out_im(out_im)
  );

  // Shared Q1.15 complex multiplier: full products, arithmetic shift, truncate.
  function automatic logic [W-1:0] cm_re(input logic signed [W-1:0] ar, ai, br, bi);
    logic signed [LW-1:0] p;
    p = LW'(ar) * LW'(br) - LW'(ai) * LW'(bi);
    p = p >>> (W - 1);
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] cm_im(input logic signed [W-1:0] ar, ai, br, bi);
    logic signed [LW-1:0] p;
    p = LW'(ar) * LW'(bi) + LW'(ai) * LW'(br);
    p = p >>> (W - 1);
    return p[W-1:0];
  endfunction

  always_comb begin
    mul_m_re = cm_re(mul_a_re, mul_a_im, mul_b_re, mul_b_im);
    mul_m_im = cm_im(mul_a_re, mul_a_im, mul_b_re, mul_b_im);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_r0(input logic v, input logic [W-1:0] ar, ai, br, bi);
    r0_valid = v; r0_a_re = ar; r0_a_im = ai; r0_b_re = br; r0_b_im = bi;
  endtask

  task automatic drive_r1(input logic v, input logic [W-1:0] ar, ai, br, bi);
    r1_valid = v; r1_a_re = ar; r1_a_im = ai; r1_b_re = br; r1_b_im = bi;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clock);
    drive_r0(1'b1, 16'h1234, 16'h1111, 16'h2222, 16'h3333);
    drive_r1(1'b1, 16'h4321, 16'h5555, 16'h6666, 16'h7777);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {r0_ready, r1_ready}); end
    checks++; if ({mul_a_re, mul_a_im, mul_b_re, mul_b_im} !== '0) begin errors++; $display("FAIL reset_mul: got %h expected 0", {mul_a_re, mul_a_im, mul_b_re, mul_b_im}); end
    checks++; if ({out_id, out_re, out_im} !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", {out_id, out_re, out_im}); end
    @(negedge clock);
    r0_valid = 1'b0; r1_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clock);
    out_ready = 1'b1;
    drive_r0(1'b1, 16'h4000, 16'h4000, 16'h4000, 16'hC000);
    #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", r0_ready); end
    @(negedge clock);
    r0_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", out_valid); end
    checks++; if ({mul_a_re, mul_a_im, mul_b_re, mul_b_im} !== 64'h4000_4000_4000_C000) begin errors++; $display("FAIL single_mul_ops: got %h expected 4000400040 00c000", {mul_a_re, mul_a_im, mul_b_re, mul_b_im}); end
    @(negedge clock);
    #1;
    checks++; if ({out_valid, out_id} !== 2'b10) begin errors++; $display("FAIL single_valid_id: got %b expected 10", {out_valid, out_id}); end
    checks++; if ({out_re, out_im} !== 32'h4000_0000) begin errors++; $display("FAIL single_result: got %h expected 40000000", {out_re, out_im}); end
    @(negedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    int k0, k1, seen;
    logic g;
    logic [W-1:0] ar0, ai1;
    logic [EW-1:0] got, exp;
    k0 = 0; k1 = 0; seen = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      ar0 = W'(16'h0400 * (k0 + 1));
      ai1 = W'(16'h0300 * (k1 + 1));
      drive_r0(i < 6, ar0, 16'h0000, 16'h4000, 16'h2000);
      drive_r1(i < 6, 16'h0000, ai1, 16'h4000, 16'h2000);
      #1;
      if (i < 6) begin
        g = i[0];
        checks++;
        if ({r1_ready, r0_ready} !== (g ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_grant[%0d]: got r1r0=%b expected grant %0d", i, {r1_ready, r0_ready}, g);
        end
        if (g) begin exp_q.push_back({1'b1, cm_re(16'h0000, ai1, 16'h4000, 16'h2000), cm_im(16'h0000, ai1, 16'h4000, 16'h2000)}); k1++; end
        else   begin exp_q.push_back({1'b0, cm_re(ar0, 16'h0000, 16'h4000, 16'h2000), cm_im(ar0, 16'h0000, 16'h4000, 16'h2000)}); k0++; end
      end
      if (i >= 2 && i < 8) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_throughput[%0d]: got out_valid %b expected 1", i, out_valid); end
      end
      if (out_valid === 1'b1) begin
        checks++; seen++;
        got = {out_id, out_re, out_im};
        if (exp_q.size() == 0) begin errors++; $display("FAIL rr_unexpected: got %h expected none", got); end
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin errors++; $display("FAIL rr_result: got %h expected %h", got, exp); end
        end
      end
    end
    checks++; if (seen != 6) begin errors++; $display("FAIL rr_count: got %0d expected 6", seen); end
  endtask

  task automatic test_backpressure();
    int k, seen;
    logic [W-1:0] ar;
    logic [EW-1:0] got, exp;
    k = 0; seen = 0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      out_ready = (i >= 5);
      ar = W'(16'h0111 * (k + 1));
      drive_r1(i <= 5, ar, 16'h0800, 16'h2000, 16'hF000);
      #1;
      if (i <= 5) begin
        checks++;
        if (r1_ready !== ((i < 2 || i == 5) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", i, r1_ready, (i < 2 || i == 5));
        end
        if (i < 2 || i == 5) begin
          exp_q.push_back({1'b1, cm_re(ar, 16'h0800, 16'h2000, 16'hF000), cm_im(ar, 16'h0800, 16'h2000, 16'hF000)});
          k++;
        end
      end
      if (i >= 2 && i < 5) begin
        checks++;
        got = {out_id, out_re, out_im};
        if (out_valid !== 1'b1 || got !== exp_q[0]) begin
          errors++; $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 %h", i, out_valid, got, exp_q[0]);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++; seen++;
        got = {out_id, out_re, out_im};
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_unexpected: got %h expected none", got); end
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin errors++; $display("FAIL bp_result: got %h expected %h", got, exp); end
        end
      end
    end
    checks++; if (seen != 3 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d drained, %0d left expected 3, 0", seen, exp_q.size()); end
  endtask

  task automatic test_priority();
    int seen;
    logic g;
    logic [W-1:0] ar;
    logic [EW-1:0] got, exp;
    logic [5:0] grants;
    grants = 6'b10_1111; // bit i is the expected grant in cycle i
    seen = 0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      out_ready = 1'b1;
      ar = W'(16'h0A00 + 16'(i));
      drive_r1(i < 4 || i == 5, ar, 16'h0100, 16'h7FFF, 16'h0000);
      drive_r0(i == 4, 16'h3000, 16'h1000, 16'h1000, 16'h3000);
      if (i == 5) drive_r1(1'b1, 16'h0A04, 16'h0100, 16'h7FFF, 16'h0000);
      #1;
      if (i < 6) begin
        g = grants[i];
        checks++;
        if ({r1_ready, r0_ready} !== (g ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL pri_grant[%0d]: got r1r0=%b expected grant %0d", i, {r1_ready, r0_ready}, g);
        end
        if (g) exp_q.push_back({1'b1, cm_re(r1_a_re, r1_a_im, r1_b_re, r1_b_im), cm_im(r1_a_re, r1_a_im, r1_b_re, r1_b_im)});
        else   exp_q.push_back({1'b0, cm_re(r0_a_re, r0_a_im, r0_b_re, r0_b_im), cm_im(r0_a_re, r0_a_im, r0_b_re, r0_b_im)});
      end
      if (out_valid === 1'b1) begin
        checks++; seen++;
        got = {out_id, out_re, out_im};
        if (exp_q.size() == 0) begin errors++; $display("FAIL pri_unexpected: got %h expected none", got); end
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin errors++; $display("FAIL pri_result: got %h expected %h", got, exp); end
        end
      end
    end
    checks++; if (seen != 6) begin errors++; $display("FAIL pri_count: got %0d expected 6", seen); end
  endtask

  task automatic test_async_reset();
    int seen;
    logic [EW-1:0] got, exp;
    seen = 0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive_r0(1'b1, W'(16'h1000 + 16'(i)), 16'h0200, 16'h4000, 16'h0000);
      #1;
      checks++;
      if (r0_ready !== (i < 2)) begin errors++; $display("FAIL ar_fill_ready[%0d]: got %b expected %b", i, r0_ready, (i < 2)); end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_full: got %b expected 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({out_valid, r0_ready, r1_ready} !== 3'b000) begin errors++; $display("FAIL ar_ctrl: got %b expected 000", {out_valid, r0_ready, r1_ready}); end
    checks++; if ({mul_a_re, mul_a_im, mul_b_re, mul_b_im, out_re, out_im} !== '0) begin errors++; $display("FAIL ar_data: got %h expected 0", {mul_a_re, mul_a_im, mul_b_re, mul_b_im, out_re, out_im}); end
    @(negedge clock);
    reset = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_stale: got %b expected 0", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      drive_r0(i == 0, 16'h2000, 16'h2000, 16'h2000, 16'h2000);
      drive_r1(i < 2, 16'h7FFF, 16'h0000, 16'h0100, 16'h0000);
      #1;
      if (i == 0) begin
        checks++; if ({r1_ready, r0_ready} !== 2'b01) begin errors++; $display("FAIL ar_first_grant: got r1r0=%b expected 01", {r1_ready, r0_ready}); end
        exp_q.push_back({1'b0, 16'h0000, 16'h1000});
      end
      if (i == 1) begin
        checks++; if ({r1_ready, r0_ready} !== 2'b10) begin errors++; $display("FAIL ar_second_grant: got r1r0=%b expected 10", {r1_ready, r0_ready}); end
        exp_q.push_back({1'b1, 16'h00FF, 16'h0000});
      end
      if (out_valid === 1'b1) begin
        checks++; seen++;
        got = {out_id, out_re, out_im};
        if (exp_q.size() == 0) begin errors++; $display("FAIL ar_unexpected: got %h expected none", got); end
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin errors++; $display("FAIL ar_result: got %h expected %h", got, exp); end
        end
      end
    end
    checks++; if (seen != 2) begin errors++; $display("FAIL ar_count: got %0d expected 2", seen); end
  endtask

  task automatic test_wrap();
    @(negedge clock);
    out_ready = 1'b1;
    drive_r0(1'b1, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
    @(negedge clock);
    r0_valid = 1'b0;
    @(negedge clock);
    #1;
    checks++; if ({out_valid, out_id} !== 2'b10) begin errors++; $display("FAIL wrap_valid_id: got %b expected 10", {out_valid, out_id}); end
    checks++; if ({out_re, out_im} !== 32'h8000_0000) begin errors++; $display("FAIL wrap_result: got %h expected 80000000", {out_re, out_im}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_priority();
    test_async_reset();
    test_wrap();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
